// File: rtl/aes128_key_expansion.sv
// AES-128 key schedule: emits round keys 0..10 over a valid/ready handshake.
// Define AES_KEYEXP_SUBWORD_PIPE_EN to register the SubWord output (two-cycle compute).

module aes128_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);
    localparam logic [255:0][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // First listed entry lands at the top packed index.
    assign o_byte = SBOX[8'hff - i_byte];
endmodule

module aes128_sub_word (
    input  logic [31:0] i_word,
    output logic [31:0] o_word
);
    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes128_sbox u_sbox (
            .i_byte(i_word[8*b +: 8]),
            .o_byte(o_word[8*b +: 8])
        );
    end
endmodule

module aes128_key_expansion #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [127:0] i_key,
    output logic [127:0] o_roundKey,
    output logic         o_roundKeyValid,
    input  logic         i_roundKeyReady,
    output logic [3:0]   o_roundIndex,
    output logic         o_busy,
    output logic         o_done
);
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_PRESENT  = 3'd1;
    localparam logic [2:0] ST_COMPUTE  = 3'd2;
    localparam logic [2:0] ST_DONE     = 3'd3;
`ifdef AES_KEYEXP_SUBWORD_PIPE_EN
    localparam logic [2:0] ST_COMPUTE2 = 3'd4;
`endif
    localparam logic [3:0] LAST_ROUND  = 4'(NUM_ROUNDS);

    logic [2:0]   state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   round_q, round_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [31:0]  rot_w, sub_w, t_w;
    logic [31:0]  w0n, w1n, w2n, w3n;
    logic [7:0]   rcon_next;

    assign rot_w = {key_q[23:0], key_q[31:24]};

    aes128_sub_word u_sub_word (
        .i_word(rot_w),
        .o_word(sub_w)
    );

`ifdef AES_KEYEXP_SUBWORD_PIPE_EN
    logic [31:0] sub_q, sub_d;
    assign t_w = sub_q ^ {rcon_q, 24'h0};
`else
    assign t_w = sub_w ^ {rcon_q, 24'h0};
`endif

    assign w0n = key_q[127:96] ^ t_w;
    assign w1n = key_q[95:64]  ^ w0n;
    assign w2n = key_q[63:32]  ^ w1n;
    assign w3n = key_q[31:0]   ^ w2n;

    assign rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        rcon_d  = rcon_q;
`ifdef AES_KEYEXP_SUBWORD_PIPE_EN
        sub_d   = sub_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    key_d   = i_key;
                    round_d = 4'd0;
                    rcon_d  = 8'h01;
                    state_d = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (i_roundKeyReady) begin
                    state_d = (round_q == LAST_ROUND) ? ST_DONE : ST_COMPUTE;
                end
            end
`ifdef AES_KEYEXP_SUBWORD_PIPE_EN
            ST_COMPUTE: begin
                sub_d   = sub_w;
                state_d = ST_COMPUTE2;
            end
            ST_COMPUTE2: begin
                key_d   = {w0n, w1n, w2n, w3n};
                round_d = round_q + 4'd1;
                rcon_d  = rcon_next;
                state_d = ST_PRESENT;
            end
`else
            ST_COMPUTE: begin
                key_d   = {w0n, w1n, w2n, w3n};
                round_d = round_q + 4'd1;
                rcon_d  = rcon_next;
                state_d = ST_PRESENT;
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            key_q   <= '0;
            round_q <= '0;
            rcon_q  <= 8'h01;
`ifdef AES_KEYEXP_SUBWORD_PIPE_EN
            sub_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
            rcon_q  <= rcon_d;
`ifdef AES_KEYEXP_SUBWORD_PIPE_EN
            sub_q   <= sub_d;
`endif
        end
    end

    assign o_roundKey      = key_q;
    assign o_roundIndex    = round_q;
    assign o_roundKeyValid = (state_q == ST_PRESENT);
    assign o_done          = (state_q == ST_DONE);
    assign o_busy          = (state_q != ST_IDLE) && (state_q != ST_DONE);
endmodule
